cam_cmd_sequencer: RTL and testbench
====================================

# cam_cmd_sequencer

Command front-end for the content-addressable memory. Accepts read/write/search commands over a valid/ready handshake and buffers them in a small FIFO. Issues them one at a time as single-cycle enables on the CAM's read/write/search ports, captures the CAM's result after a fixed latency, and returns it on a valid/ready response channel. Sits directly upstream of the CAM and is the only driver of its enable/index/data inputs.

## Interface
- WIDTH, 32, data/key width; matches CAM WIDTH
- ADDR_WIDTH, 5, CAM index width
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2
- CAM_LATENCY, 1, cycles from CAM enable to CAM valid output; at least 1

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_op_i  in  2  00 read, 01 write, 10 search, 11 reserved
- cmd_index_i  in  ADDR_WIDTH  read/write index
- cmd_data_i  in  WIDTH  write data or search key
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_op_o  out  2  opcode of completed command
- rsp_hit_o  out  1  read valid / search match / write done (1); reserved (0)
- rsp_index_o  out  ADDR_WIDTH  search: matched index; read/write: command index
- rsp_data_o  out  WIDTH  read: value; write/search: command data
- cam_read_enable_o, cam_write_enable_o, cam_search_enable_o  out  1 each  single-cycle CAM strobes
- cam_read_index_o, cam_write_index_o  out  ADDR_WIDTH  CAM indices
- cam_write_data_o, cam_search_data_o  out  WIDTH  CAM data
- cam_read_valid_i, cam_search_valid_i  in  1  CAM result flags
- cam_read_value_i  in  WIDTH  CAM read data
- cam_search_index_i  in  ADDR_WIDTH  CAM match index

## Operation
- cmd_ready_o = FIFO not full. A push occurs on cmd_valid_i & cmd_ready_o. The FIFO is popped only in ISSUE.
- FSM states and transitions:
  - IDLE: go to ISSUE when the FIFO is non-empty.
  - ISSUE: drive the strobe for the head opcode for exactly one cycle and pop. Write goes to RESP; reserved goes to RESP with no strobe; read/search goes to WAIT.
  - WAIT: count CAM_LATENCY cycles. On the last cycle, capture cam_*_valid_i, value and index into the response register, then go to RESP.
  - RESP: hold rsp_valid_o and all rsp_* stable until rsp_ready_i; then go to IDLE.
- At most one strobe is high in any cycle. Index/data outputs follow the FIFO head in ISSUE and are 0 otherwise.
- Commands complete strictly in acceptance order. There is exactly one response per accepted command.
- Simultaneous push and pop in ISSUE is legal. Occupancy is unchanged in that case.
- Reset (any cycle, including mid-WAIT or RESP) empties the FIFO, returns the FSM to IDLE and discards any in-flight command.
- Reset values: all outputs 0, except cmd_ready_o = 1 once reset deasserts.

## Timing
- Command accepted at edge ending cycle N: IDLE sees non-empty in N+1, ISSUE strobe in N+2.
- Read/search with CAM_LATENCY=L: CAM result sampled at the end of cycle N+2+L, rsp_valid_o high from cycle N+3+L.
- Write/reserved: rsp_valid_o high from cycle N+3.
- Back-to-back throughput with rsp_ready_i held high: one read/search per L+3 cycles, one write per 3 cycles.
- Response registers are flopped; no combinational path from rsp_ready_i to cmd_ready_o.

## Configuration
- CAM_CMD_SEQ_STATS_EN defined:
  - Adds stat_clear_i (in, 1), stat_search_o (out, 16) and stat_hit_o (out, 16).
  - stat_search_o counts search strobes; stat_hit_o counts search responses with hit=1.
  - Both counters saturate at 16'hFFFF.
  - Synchronous stat_clear_i zeroes both and takes priority over a same-cycle increment. rst_i zeroes both.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package cam_pkg:
  - cam_op_e enum (CAM_OP_READ, CAM_OP_WRITE, CAM_OP_SEARCH, CAM_OP_RSVD).
  - cam_cmd_t packed struct (op, index, data).
  - Sequencer state enum.
- One sub-module: cam_cmd_fifo. Synchronous FIFO of cam_cmd_t with full/empty flags, pointers one bit wider than the address, and async active-high reset.

## Test plan
- Reset mid-WAIT: after reset, rsp_valid_o=0, all strobes 0, cmd_ready_o=1, FIFO empty; the next command completes normally.
- Write idx 3 data 32'hDEAD_BEEF, then search key 32'hDEAD_BEEF, with the CAM model returning match idx 3 -> write rsp hit=1 at N+3; search rsp hit=1, index 3.
- Read idx 7 with CAM model read_valid=0 -> rsp op=00, hit=0, index 7.
- Push 5 commands with FIFO_DEPTH=4 and rsp_ready_i=0 -> cmd_ready_o drops after the 5th accept (4 queued plus 1 in RESP); responses drain in order once rsp_ready_i rises.
- Reserved opcode 11 -> no strobe asserted; rsp hit=0 at N+3.
- With CAM_CMD_SEQ_STATS_EN: 3 searches with 2 hits -> stat_search_o=3, stat_hit_o=2; stat_clear_i asserted on a hit cycle -> both read 0 the next cycle.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared CAM opcode, command record and sequencer state types
package cam_pkg;
  localparam int CAM_WIDTH = 32;
  localparam int CAM_ADDR_WIDTH = 5;
  typedef enum logic [1:0] {
    CAM_OP_READ   = 2'b00,
    CAM_OP_WRITE  = 2'b01,
    CAM_OP_SEARCH = 2'b10,
    CAM_OP_RSVD   = 2'b11
  } cam_op_e;
  typedef struct packed {
    cam_op_e                   op;
    logic [CAM_ADDR_WIDTH-1:0] index;
    logic [CAM_WIDTH-1:0]      data;
  } cam_cmd_t;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_ISSUE, SEQ_WAIT, SEQ_RESP} seq_state_e;
endpackage

// File: rtl/cam_cmd_sequencer_if.sv
// cam_cmd_sequencer_if: command, response and CAM-port signals of the sequencer
// Statistics signals exist only when CAM_CMD_SEQ_STATS_EN is defined.
interface cam_cmd_sequencer_if #(parameter int WIDTH = 32, parameter int ADDR_WIDTH = 5);
  logic                  cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_hit;
  logic [1:0]            cmd_op, rsp_op;
  logic [ADDR_WIDTH-1:0] cmd_index, rsp_index, cam_read_index, cam_write_index, cam_search_index;
  logic [WIDTH-1:0]      cmd_data, rsp_data, cam_write_data, cam_search_data, cam_read_value;
  logic                  cam_read_enable, cam_write_enable, cam_search_enable;
  logic                  cam_read_valid, cam_search_valid;
`ifdef CAM_CMD_SEQ_STATS_EN
  logic                  stat_clear;
  logic [15:0]           stat_search, stat_hit;
`endif
  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_data, rsp_ready,
    output cam_read_valid, cam_search_valid, cam_read_value, cam_search_index,
    input  cmd_ready, rsp_valid, rsp_op, rsp_hit, rsp_index, rsp_data,
    input  cam_read_enable, cam_write_enable, cam_search_enable,
    input  cam_read_index, cam_write_index, cam_write_data, cam_search_data
`ifdef CAM_CMD_SEQ_STATS_EN
    , output stat_clear, input stat_search, stat_hit
`endif
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_data, rsp_ready,
    input  cam_read_valid, cam_search_valid, cam_read_value, cam_search_index,
    output cmd_ready, rsp_valid, rsp_op, rsp_hit, rsp_index, rsp_data,
    output cam_read_enable, cam_write_enable, cam_search_enable,
    output cam_read_index, cam_write_index, cam_write_data, cam_search_data
`ifdef CAM_CMD_SEQ_STATS_EN
    , input stat_clear, output stat_search, stat_hit
`endif
  );
endinterface

// File: rtl/cam_cmd_fifo.sv
// cam_cmd_fifo: synchronous command FIFO using pointers with an extra wrap bit
module cam_cmd_fifo
  import cam_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cam_cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/cam_cmd_sequencer.sv
// cam_cmd_sequencer: queues CAM commands, issues one strobe at a time, returns results in order
// Optional search/hit statistics counters are enabled by CAM_CMD_SEQ_STATS_EN.
module cam_cmd_sequencer
  import cam_pkg::*;
#(
  parameter int WIDTH       = CAM_WIDTH,
  parameter int ADDR_WIDTH  = CAM_ADDR_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int CAM_LATENCY = 1
) (
  input logic                clk_i,
  input logic                rst_i,
  cam_cmd_sequencer_if.slave bus
);
  typedef struct packed {
    cam_op_e               op;
    logic [ADDR_WIDTH-1:0] index;
    logic [WIDTH-1:0]      data;
  } cmd_t;
  localparam int CW = CAM_LATENCY > 1 ? $clog2(CAM_LATENCY) : 1;
  seq_state_e state;
  cmd_t       wdata, head;
  logic       full, empty, wait_op;
  logic [CW-1:0] cnt;
  assign bus.cmd_ready = !full;
  assign wdata = '{op: cam_op_e'(bus.cmd_op), index: bus.cmd_index, data: bus.cmd_data};
  assign wait_op = head.op == CAM_OP_READ || head.op == CAM_OP_SEARCH;
  cam_cmd_fifo #(.DEPTH(FIFO_DEPTH), .T(cmd_t)) u_fifo (
    .clk(clk_i), .rst(rst_i), .push(bus.cmd_valid && !full), .pop(state == SEQ_ISSUE),
    .wdata(wdata), .rdata(head), .full(full), .empty(empty)
  );
  // CAM strobes and operands are loaded on entry to ISSUE so they are high exactly during ISSUE
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state                 <= SEQ_IDLE;
      cnt                   <= '0;
      bus.cam_read_enable   <= 1'b0;
      bus.cam_write_enable  <= 1'b0;
      bus.cam_search_enable <= 1'b0;
      bus.cam_read_index    <= '0;
      bus.cam_write_index   <= '0;
      bus.cam_write_data    <= '0;
      bus.cam_search_data   <= '0;
      bus.rsp_valid         <= 1'b0;
      bus.rsp_op            <= '0;
      bus.rsp_hit           <= 1'b0;
      bus.rsp_index         <= '0;
      bus.rsp_data          <= '0;
    end else begin
      bus.cam_read_enable   <= 1'b0;
      bus.cam_write_enable  <= 1'b0;
      bus.cam_search_enable <= 1'b0;
      bus.cam_read_index    <= '0;
      bus.cam_write_index   <= '0;
      bus.cam_write_data    <= '0;
      bus.cam_search_data   <= '0;
      case (state)
        SEQ_IDLE: if (!empty) begin
          state                 <= SEQ_ISSUE;
          bus.cam_read_enable   <= head.op == CAM_OP_READ;
          bus.cam_write_enable  <= head.op == CAM_OP_WRITE;
          bus.cam_search_enable <= head.op == CAM_OP_SEARCH;
          bus.cam_read_index    <= head.index;
          bus.cam_write_index   <= head.index;
          bus.cam_write_data    <= head.data;
          bus.cam_search_data   <= head.data;
        end
        SEQ_ISSUE: begin
          state         <= wait_op ? SEQ_WAIT : SEQ_RESP;
          bus.rsp_valid <= !wait_op;
          bus.rsp_op    <= head.op;
          bus.rsp_hit   <= head.op == CAM_OP_WRITE;
          bus.rsp_index <= head.index;
          bus.rsp_data  <= head.data;
          cnt           <= '0;
        end
        SEQ_WAIT: if (cnt == CW'(CAM_LATENCY - 1)) begin
          state         <= SEQ_RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_hit   <= bus.rsp_op == CAM_OP_READ ? bus.cam_read_valid : bus.cam_search_valid;
          bus.rsp_data  <= bus.rsp_op == CAM_OP_READ ? bus.cam_read_value : bus.rsp_data;
          bus.rsp_index <= bus.rsp_op == CAM_OP_READ ? bus.rsp_index : bus.cam_search_index;
        end else cnt <= cnt + 1'b1;
        SEQ_RESP: if (bus.rsp_ready) begin
          state         <= SEQ_IDLE;
          bus.rsp_valid <= 1'b0;
        end
        default: state <= SEQ_IDLE;
      endcase
    end
`ifdef CAM_CMD_SEQ_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bus.stat_search <= '0;
      bus.stat_hit    <= '0;
    end else if (bus.stat_clear) begin
      bus.stat_search <= '0;
      bus.stat_hit    <= '0;
    end else begin
      if (bus.cam_search_enable && !(&bus.stat_search)) bus.stat_search <= bus.stat_search + 1'b1;
      if (bus.rsp_valid && bus.rsp_ready && bus.rsp_op == CAM_OP_SEARCH && bus.rsp_hit && !(&bus.stat_hit))
        bus.stat_hit <= bus.stat_hit + 1'b1;
    end
`endif
endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// tb_cam_cmd_sequencer: directed bench for cam_cmd_sequencer with a small behavioural CAM
module tb_cam_cmd_sequencer;
  logic clk = 1'b0, rst = 1'b1, init = 1'b1;
  int   cyc = 0, n_chk = 0, n_fail = 0, t_acc = 0;
  logic [31:0] mem [32];
  logic [31:0] vld;
  logic [5:0]  fm;
  localparam logic [31:0] A = 32'h1111_AAAA, B = 32'h2222_BBBB, C = 32'h3333_CCCC, DB = 32'hDEAD_BEEF;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cam_cmd_sequencer_if bus ();
  cam_cmd_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  // CAM model: one-cycle latency, lowest matching index wins; contents survive sequencer resets
  always_comb begin
    fm = '0;
    for (int i = 31; i >= 0; i--) if (vld[i] && mem[i] == bus.cam_search_data) fm = {1'b1, 5'(i)};
  end
  always @(posedge clk) begin
    bus.cam_read_valid   <= bus.cam_read_enable && vld[bus.cam_read_index];
    bus.cam_read_value   <= vld[bus.cam_read_index] ? mem[bus.cam_read_index] : 32'h0;
    bus.cam_search_valid <= bus.cam_search_enable && fm[5];
    bus.cam_search_index <= fm[4:0];
    if (init) vld <= '0;
    else if (bus.cam_write_enable) begin
      mem[bus.cam_write_index] <= bus.cam_write_data;
      vld[bus.cam_write_index] <= 1'b1;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_index = idx; bus.cmd_data = data;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("push_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    t_acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic expect_rsp(input string tag, input logic [1:0] op, input logic hit, input logic [4:0] idx,
                            input logic [31:0] data, input int lat, input logic [2:0] strobes);
    int n = 0;
    logic [2:0] seen = '0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 100) begin
      seen |= {bus.cam_search_enable, bus.cam_write_enable, bus.cam_read_enable};
      @(negedge clk); n++;
    end
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_latency"}, 64'(cyc - t_acc), 64'(lat));
    chk({tag, "_strobes"}, 64'(seen), 64'(strobes));
    chk({tag, "_rsp"}, 64'({bus.rsp_op, bus.rsp_hit, bus.rsp_index, bus.rsp_data}), 64'({op, hit, idx, data}));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "_drop"}, 64'(bus.rsp_valid), 64'd0);
  endtask
  initial begin
    int k, n;
    logic [2:0] seen;
    logic [39:0] exp_q [5];
    exp_q = '{{2'b01, 1'b1, 5'd10, A}, {2'b01, 1'b1, 5'd11, B}, {2'b00, 1'b1, 5'd10, A},
              {2'b10, 1'b1, 5'd11, B}, {2'b11, 1'b0, 5'd4, C}};
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_index = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
`ifdef CAM_CMD_SEQ_STATS_EN
    bus.stat_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 init = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_strobes", 64'({bus.cam_search_enable, bus.cam_write_enable, bus.cam_read_enable}), 64'd0);
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("reset_rsp_fields", 64'({bus.rsp_op, bus.rsp_hit, bus.rsp_index, bus.rsp_data}), 64'd0);
    push(2'b01, 5'd3, DB);
    expect_rsp("write3", 2'b01, 1'b1, 5'd3, DB, 2, 3'b010);
    push(2'b10, 5'd0, DB);
    expect_rsp("search_db", 2'b10, 1'b1, 5'd3, DB, 3, 3'b100);
    push(2'b00, 5'd7, 32'h0);
    expect_rsp("read7", 2'b00, 1'b0, 5'd7, 32'h0, 3, 3'b001);
    push(2'b00, 5'd3, 32'h0);
    expect_rsp("read3", 2'b00, 1'b1, 5'd3, DB, 3, 3'b001);
    push(2'b11, 5'd9, 32'hCAFE);
    expect_rsp("rsvd", 2'b11, 1'b0, 5'd9, 32'hCAFE, 2, 3'b000);
    // reset while a read waits on the CAM
    push(2'b00, 5'd3, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midwait_rst_strobes", 64'({bus.cam_search_enable, bus.cam_write_enable, bus.cam_read_enable}), 64'd0);
    @(negedge clk) rst = 1'b0;
    chk("midwait_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midwait_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    seen = '0;
    repeat (10) begin
      @(negedge clk);
      seen |= {bus.rsp_valid, bus.cam_read_enable | bus.cam_write_enable | bus.cam_search_enable, 1'b0};
    end
    chk("midwait_flushed", 64'(seen), 64'd0);
    push(2'b01, 5'd5, 32'h5555_0005);
    expect_rsp("after_rst_write", 2'b01, 1'b1, 5'd5, 32'h5555_0005, 2, 3'b010);
    // five back-to-back commands against a stalled response channel
    push(2'b01, 5'd10, A);
    push(2'b01, 5'd11, B);
    push(2'b00, 5'd10, 32'h0);
    push(2'b10, 5'd0, B);
    push(2'b11, 5'd4, C);
    @(negedge clk);
    chk("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    k = 0; n = 0;
    while (k < 5 && n < 200) begin
      if (bus.rsp_valid) begin
        chk($sformatf("drain%0d", k), 64'({bus.rsp_op, bus.rsp_hit, bus.rsp_index, bus.rsp_data}), 64'(exp_q[k]));
        k++;
      end
      @(negedge clk); n++;
    end
    bus.rsp_ready = 1'b0;
    chk("drain_count", 64'(k), 64'd5);
    chk("drain_ready_back", 64'(bus.cmd_ready), 64'd1);
`ifdef CAM_CMD_SEQ_STATS_EN
    @(negedge clk) bus.stat_clear = 1'b1;
    @(negedge clk) bus.stat_clear = 1'b0;
    chk("stat_cleared", 64'({bus.stat_search, bus.stat_hit}), 64'd0);
    push(2'b10, 5'd0, DB);
    expect_rsp("stat_s1", 2'b10, 1'b1, 5'd3, DB, 3, 3'b100);
    push(2'b10, 5'd0, B);
    expect_rsp("stat_s2", 2'b10, 1'b1, 5'd11, B, 3, 3'b100);
    push(2'b10, 5'd0, 32'h1234_5678);
    expect_rsp("stat_s3", 2'b10, 1'b0, 5'd0, 32'h1234_5678, 3, 3'b100);
    chk("stat_search3", 64'(bus.stat_search), 64'd3);
    chk("stat_hit2", 64'(bus.stat_hit), 64'd2);
    push(2'b10, 5'd0, DB);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("stat_s4_valid", 64'(bus.rsp_valid), 64'd1);
    chk("stat_search4", 64'(bus.stat_search), 64'd4);
    bus.rsp_ready = 1'b1; bus.stat_clear = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0; bus.stat_clear = 1'b0;
    chk("stat_clear_on_hit", 64'({bus.stat_search, bus.stat_hit}), 64'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
